// File: rtl/dco_nco.sv
// Numerically controlled oscillator: phase accumulator driven by a tuning word that
// slews toward each new request in bounded steps.
module dco_nco #(
  parameter int unsigned      ACC_W     = 24,
  parameter logic [ACC_W-1:0] RESET_FCW = ACC_W'(24'h100000),
  parameter logic [ACC_W-1:0] MAX_STEP  = ACC_W'(24'h000400)
) (
  input  logic             clk160_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [ACC_W-1:0] fcw_i,
  input  logic             fcw_valid_i,
  output logic             fcw_ready_o,
  output logic [ACC_W-1:0] fcw_o,
  output logic [ACC_W-1:0] phase_o,
  output logic             dco_o,
  output logic             tick_o,
  output logic             slewing_o
);

  localparam int unsigned EXT_W = ACC_W + 1;

  typedef enum logic {IDLE, SLEW} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     fcw_q, fcw_d;
  logic [ACC_W-1:0]     target_q, target_d;
  logic [ACC_W-1:0]     phase_q;
  logic                 ready_q, ready_d;
  logic                 slewing_q, slewing_d;
  logic                 tick_q;
  logic                 accept;
  logic signed [ACC_W:0] req_diff, slew_diff;
  logic [EXT_W-1:0]     req_dist, slew_dist, step_ext;
  logic [EXT_W-1:0]     phase_sum;

  // Distances kept one bit wider and signed so neither direction can wrap.
  always_comb begin
    step_ext  = {1'b0, MAX_STEP};
    req_diff  = $signed({1'b0, fcw_i})    - $signed({1'b0, fcw_q});
    slew_diff = $signed({1'b0, target_q}) - $signed({1'b0, fcw_q});
    req_dist  = req_diff[ACC_W]  ? $unsigned(-req_diff)  : $unsigned(req_diff);
    slew_dist = slew_diff[ACC_W] ? $unsigned(-slew_diff) : $unsigned(slew_diff);
    phase_sum = {1'b0, phase_q} + {1'b0, fcw_q};
  end

  // Next-state and tuning-word update.
  always_comb begin
    state_d  = state_q;
    fcw_d    = fcw_q;
    target_d = target_q;
    accept   = fcw_valid_i && ready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = fcw_i;
          if (req_dist <= step_ext) fcw_d = fcw_i;
          else                      state_d = SLEW;
        end
      end
      SLEW: begin
        if (slew_dist <= step_ext) begin
          fcw_d   = target_q;
          state_d = IDLE;
        end else if (slew_diff[ACC_W]) begin
          fcw_d = fcw_q - MAX_STEP;
        end else begin
          fcw_d = fcw_q + MAX_STEP;
        end
      end
    endcase
    ready_d   = (state_d == IDLE);
    slewing_d = (state_d == SLEW);
  end

  always_ff @(posedge clk160_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      fcw_q     <= RESET_FCW;
      target_q  <= RESET_FCW;
      ready_q   <= 1'b0;
      slewing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcw_q     <= fcw_d;
      target_q  <= target_d;
      ready_q   <= ready_d;
      slewing_q <= slewing_d;
    end
  end

  // Phase accumulator; the carry out of the sum becomes the wrap tick.
  always_ff @(posedge clk160_i) begin
    if (reset_i) begin
      phase_q <= '0;
      tick_q  <= 1'b0;
    end else if (enable_i) begin
      phase_q <= phase_sum[ACC_W-1:0];
      tick_q  <= phase_sum[ACC_W];
    end else begin
      tick_q  <= 1'b0;
    end
  end

  assign fcw_ready_o = ready_q;
  assign fcw_o       = fcw_q;
  assign phase_o     = phase_q;
  assign dco_o       = phase_q[ACC_W-1];
  assign tick_o      = tick_q;
  assign slewing_o   = slewing_q;

endmodule

// File: tb/tb_dco_nco.sv
// Directed bench for dco_nco: tuning-word changes are checked by a scoreboard
// monitor, phase/tick/handshake by inline checks.
module tb_dco_nco;

  localparam int unsigned ACC_W = 24;
  localparam logic [23:0] STEP  = 24'h000400;

  logic        clk160_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [23:0] fcw_i;
  logic        fcw_valid_i;
  logic        fcw_ready_o;
  logic [23:0] fcw_o;
  logic [23:0] phase_o;
  logic        dco_o;
  logic        tick_o;
  logic        slewing_o;

  dco_nco #(
    .ACC_W    (ACC_W),
    .RESET_FCW(24'h100000),
    .MAX_STEP (STEP)
  ) dut (
    .clk160_i   (clk160_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .fcw_i      (fcw_i),
    .fcw_valid_i(fcw_valid_i),
    .fcw_ready_o(fcw_ready_o),
    .fcw_o      (fcw_o),
    .phase_o    (phase_o),
    .dco_o      (dco_o),
    .tick_o     (tick_o),
    .slewing_o  (slewing_o)
  );

  always #5 clk160_i = ~clk160_i;

  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [23:0] prev_fcw;
  logic [23:0] mon_exp;
  logic [23:0] model_fcw;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h at %0t", name, act, exp, $time);
    end
  endtask

  // Every change of fcw_o must match the next queued expected tuning word.
  always @(negedge clk160_i) begin
    if (mon_en && fcw_o !== prev_fcw) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fcw_unexpected: got 0x%06h, expected it to stay 0x%06h at %0t",
                 fcw_o, prev_fcw, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fcw_o !== mon_exp) begin
          errors++;
          $display("FAIL fcw_seq: got 0x%06h expected 0x%06h at %0t", fcw_o, mon_exp, $time);
        end
      end
      prev_fcw = fcw_o;
    end
  end

  // Queue the tuning words a request should produce; n = expected slew cycles.
  task automatic plan(input logic [23:0] cur, input logic [23:0] tgt, output int n);
    longint v, t, d;
    v = longint'(cur);
    t = longint'(tgt);
    n = 0;
    d = (t > v) ? t - v : v - t;
    if (d <= longint'(STEP)) begin
      if (t != v) exp_q.push_back(tgt);
    end else begin
      while (d > longint'(STEP)) begin
        v = (t > v) ? v + longint'(STEP) : v - longint'(STEP);
        exp_q.push_back(24'(v));
        n++;
        d = (t > v) ? t - v : v - t;
      end
      exp_q.push_back(tgt);
      n++;
    end
  endtask

  // Count cycles spent slewing until idle; optionally poke a stray request mid-slew.
  task automatic wait_idle(input bit inject, output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (fcw_ready_o === 1'b1 && slewing_o === 1'b0) begin
        done = 1'b1;
      end else begin
        if (slewing_o === 1'b1) n++;
        fcw_valid_i = inject && (n == 2);
        fcw_i       = 24'h000100;
        @(negedge clk160_i);
      end
    end
    fcw_valid_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout: ready=%b slewing=%b, required ready=1 slewing=0",
               fcw_ready_o, slewing_o);
    end
  endtask

  task automatic issue(input logic [23:0] w, input bit inject, input string name);
    int exp_n, n;
    plan(model_fcw, w, exp_n);
    model_fcw   = w;
    fcw_i       = w;
    fcw_valid_i = 1'b1;
    @(negedge clk160_i);
    fcw_valid_i = 1'b0;
    wait_idle(inject, n);
    chk(name, 24'(n), 24'(exp_n));
  endtask

  int n_dummy;

  initial begin
    reset_i     = 1'b1;
    enable_i    = 1'b0;
    fcw_i       = '0;
    fcw_valid_i = 1'b0;
    model_fcw   = 24'h100000;
    repeat (4) @(negedge clk160_i);
    chk("rst_phase",   phase_o,          24'h0);
    chk("rst_tick",    24'(tick_o),      24'd0);
    chk("rst_dco",     24'(dco_o),       24'd0);
    chk("rst_fcw",     fcw_o,            24'h100000);
    chk("rst_slewing", 24'(slewing_o),   24'd0);
    chk("rst_ready",   24'(fcw_ready_o), 24'd0);
    prev_fcw = 24'h100000;
    mon_en   = 1'b1;

    // Free run from reset: 0x100000 per cycle wraps every 16 cycles.
    reset_i  = 1'b0;
    enable_i = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk160_i);
      if (i == 1) chk("ready_after_rst", 24'(fcw_ready_o), 24'd1);
      chk("run_phase", phase_o, 24'(i * 32'h100000));
      chk("run_tick",  24'(tick_o), 24'((i % 16) == 0));
      chk("run_dco",   24'(dco_o),  24'((i % 16) >= 8));
    end

    // Small step with accumulator running: new word applies one cycle later.
    plan(model_fcw, 24'h100200, n_dummy);
    model_fcw   = 24'h100200;
    fcw_i       = 24'h100200;
    fcw_valid_i = 1'b1;
    @(negedge clk160_i);
    fcw_valid_i = 1'b0;
    chk("small_phase1",  phase_o,          24'h100000);
    chk("small_slewing", 24'(slewing_o),   24'd0);
    chk("small_ready",   24'(fcw_ready_o), 24'd1);
    @(negedge clk160_i);
    chk("small_phase2", phase_o, 24'h200200);
    enable_i = 1'b0;
    @(negedge clk160_i);
    chk("hold_phase", phase_o, 24'h200200);

    issue(24'h100000, 1'b0, "back_to_base");
    issue(24'h101000, 1'b1, "slew_up_cycles");
    issue(24'h000900, 1'b0, "slew_down_long");
    issue(24'h000100, 1'b0, "slew_clamp_cycles");

    // Reset in the middle of a long slew, with a request held during reset.
    exp_q.push_back(24'h000500);
    exp_q.push_back(24'h000900);
    exp_q.push_back(24'h000D00);
    fcw_i       = 24'h101000;
    fcw_valid_i = 1'b1;
    @(negedge clk160_i);
    fcw_valid_i = 1'b0;
    chk("midslew_slewing", 24'(slewing_o), 24'd1);
    repeat (3) @(negedge clk160_i);
    reset_i     = 1'b1;
    fcw_valid_i = 1'b1;
    fcw_i       = 24'h100100;
    exp_q.push_back(24'h100000);
    @(negedge clk160_i);
    chk("midrst_phase",   phase_o,          24'h0);
    chk("midrst_ready",   24'(fcw_ready_o), 24'd0);
    chk("midrst_slewing", 24'(slewing_o),   24'd0);
    @(negedge clk160_i);
    chk("midrst_ready2", 24'(fcw_ready_o), 24'd0);
    reset_i     = 1'b0;
    fcw_valid_i = 1'b0;
    @(negedge clk160_i);
    chk("postrst_ready", 24'(fcw_ready_o), 24'd1);
    chk("postrst_fcw",   fcw_o,            24'h100000);
    model_fcw = 24'h100000;

    // Enable low freezes phase while a slew still runs to completion.
    enable_i = 1'b1;
    repeat (5) @(negedge clk160_i);
    chk("pre_hold_phase", phase_o, 24'h500000);
    enable_i = 1'b0;
    plan(model_fcw, 24'h102000, n_dummy);
    chk("hold_plan_steps", 24'(n_dummy), 24'd8);
    model_fcw   = 24'h102000;
    fcw_i       = 24'h102000;
    fcw_valid_i = 1'b1;
    @(negedge clk160_i);
    fcw_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("frozen_phase", phase_o,     24'h500000);
      chk("frozen_tick",  24'(tick_o), 24'd0);
      @(negedge clk160_i);
    end
    chk("hold_slew_done_ready", 24'(fcw_ready_o), 24'd1);
    chk("hold_slew_done_fcw",   fcw_o,            24'h102000);

    // Zero tuning word: phase stays put and never ticks.
    issue(24'h000000, 1'b0, "slew_to_zero");
    enable_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk160_i);
      chk("zero_phase", phase_o,     24'h500000);
      chk("zero_tick",  24'(tick_o), 24'd0);
    end
    enable_i = 1'b0;

    // Request equal to the current word: accepted, no slew, no change.
    issue(24'h000000, 1'b0, "equal_req_cycles");
    chk("equal_ready", 24'(fcw_ready_o), 24'd1);
    repeat (2) @(negedge clk160_i);

    chk("queue_empty", 24'(exp_q.size()), 24'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dco_nco.md
DCO_NCO -- requirements
Module: dco_nco

Interface
REQ-001 SHALL have parameter ACC_W, default 24: phase accumulator and tuning-word width in bits.
REQ-002 SHALL have parameter RESET_FCW, default 24'h100000: tuning word loaded at reset, giving 10 MHz at a 160 MHz clock.
REQ-003 SHALL have parameter MAX_STEP, default 24'h000400: maximum change of the active tuning word per clock during slew.
REQ-004 SHALL have port clk160_i  input  1: sole clock (160 MHz from the clock/reset generator); all logic on its rising edge.
REQ-005 SHALL have port reset_i  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port enable_i  input  1: when high, the accumulator advances.
REQ-007 SHALL have port fcw_i  input  ACC_W: requested frequency control word (unsigned).
REQ-008 SHALL have port fcw_valid_i  input  1: fcw_i holds a new request.
REQ-009 SHALL have port fcw_ready_o  output  1: block can accept a request.
REQ-010 SHALL have port fcw_o  output  ACC_W: active tuning word currently applied.
REQ-011 SHALL have port phase_o  output  ACC_W: accumulator value.
REQ-012 SHALL have port dco_o  output  1: equals phase_o[ACC_W-1], a square-wave DCO output.
REQ-013 SHALL have port tick_o  output  1: one-cycle pulse on accumulator wrap.
REQ-014 SHALL have port slewing_o  output  1: high while the FSM is in SLEW.

Function
REQ-015 SHALL, each cycle with enable_i=1, set phase_o <= (phase_o + fcw_o) mod 2^ACC_W, using the fcw_o value from before the edge.
REQ-016 SHALL assert tick_o for exactly the cycle after an update whose unsigned sum carried out of bit ACC_W-1.
REQ-017 SHALL, with enable_i=0, hold phase_o and drive tick_o=0, while slew continues unaffected.
REQ-018 SHALL, when fcw_o=0 and enable_i=1, hold phase_o constant and never assert tick_o.
REQ-019 SHALL implement a two-state FSM, IDLE and SLEW, with fcw_ready_o=1 only in IDLE and slewing_o=1 only in SLEW.
REQ-020 SHALL accept a request when fcw_valid_i and fcw_ready_o are both high on a rising edge, latching fcw_i into target.
- fcw_valid_i is ignored while fcw_ready_o=0.
- No request is queued.
REQ-021 SHALL handle IDLE with an accepted request as follows:
- If |target-fcw_o| <= MAX_STEP: load fcw_o=fcw_i on that edge and stay IDLE.
- Otherwise: go to SLEW, with fcw_o unchanged on that edge.
REQ-022 SHALL handle SLEW each cycle by moving fcw_o toward target by exactly MAX_STEP; when the remaining distance is <= MAX_STEP, it sets fcw_o=target and returns to IDLE on that edge.
REQ-023 SHALL compute slew distance and steps in ACC_W+1-bit signed arithmetic: no wrap-around, and fcw_o never overshoots the target or leaves the range 0..2^ACC_W-1.
REQ-024 SHALL, for a request equal to the current fcw_o, accept it, stay IDLE, and leave fcw_o unchanged.
REQ-025 SHALL make the new fcw_o take effect in the accumulator from the cycle after it is registered (one-cycle latency from fcw_o to phase increment).

Reset
REQ-026 SHALL, on a clock edge with reset_i=1, set:
- phase_o=0, tick_o=0, dco_o=0
- fcw_o=RESET_FCW, target=RESET_FCW
- FSM to IDLE, slewing_o=0
REQ-027 SHALL hold fcw_ready_o=0 during any cycle in which reset_i is high, ignoring fcw_valid_i, and drive fcw_ready_o=1 on the first edge after reset_i falls.
REQ-028 SHALL treat reset asserted mid-slew identically: the slew is abandoned and fcw_o returns to RESET_FCW.
REQ-029 SHALL give reset priority over enable_i and over handshake activity.

Verification
REQ-030 SHALL verify the reset run: reset 4 cycles, then enable_i=1 for 32 cycles -> phase_o=32*0x100000 mod 2^24=0, with tick_o pulsing every 16 cycles and dco_o toggling every 8.
REQ-031 SHALL verify a small step: request 0x100200 in IDLE -> accepted in 1 cycle, fcw_o=0x100200 the next cycle, slewing_o never high.
REQ-032 SHALL verify a large step: request 0x101000 from 0x100000 -> SLEW for 4 cycles, with fcw_o = 0x100400, 0x100800, 0x100C00, 0x101000, then fcw_ready_o=1 again.
REQ-033 SHALL verify a downward slew with clamp: request 0x000100 from 0x000900 -> fcw_o = 0x000500, then 0x000100, with no underflow.
REQ-034 SHALL verify that while in SLEW, a second fcw_valid_i pulse with a different word is ignored and the target is unchanged.
REQ-035 SHALL verify reset mid-slew and enable-low hold:
- reset_i during SLEW -> next cycle fcw_o=0x100000, phase_o=0, fcw_ready_o=1 after release.
- enable_i=0 for 10 cycles -> phase_o frozen, tick_o=0, slew still completes.
